// File: rtl/mine_board_builder_if.sv
// Handshake/bus bundle between the minesweeper game logic and the board builder.
// master: requester (drives start/bombas/safe_x/safe_y); slave: builder (drives busy/done/wr_*/placed).
interface mine_board_builder_if;
    logic       start;
    logic [3:0] bombas;
    logic [2:0] safe_x;
    logic [2:0] safe_y;
    logic       busy;
    logic       done;
    logic       wr_en;
    logic [2:0] wr_x;
    logic [2:0] wr_y;
    logic [3:0] wr_code;
    logic [3:0] placed;

    modport master (
        output start, bombas, safe_x, safe_y,
        input  busy, done, wr_en, wr_x, wr_y, wr_code, placed
    );

    modport slave (
        input  start, bombas, safe_x, safe_y,
        output busy, done, wr_en, wr_x, wr_y, wr_code, placed
    );
endinterface

// File: rtl/mine_board_builder.sv
// 8x8 minesweeper board generator: clears the board, places LFSR-driven bombs
// away from the first-clicked cell, then writes every cell's code (9 = bomb,
// else neighbour count).
// Ports: clk, reset (async active-low), bus (slave modport: start, bombas,
// safe_x, safe_y in; busy, done, wr_en, wr_x, wr_y, wr_code, placed out).
// Build option: define SAFE_ZONE_EN to keep bombs out of the whole 3x3 area
// around the safe cell instead of just the safe cell itself.
module mine_board_builder #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [3:0]  CODE_BOMB = 4'd9,
    parameter int unsigned MAX_BOMBS = 15
) (
    input logic clk,
    input logic reset,
    mine_board_builder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, PLACE, COUNT, DONE
    } state_t;

    localparam logic [3:0] MAX_N = MAX_BOMBS[3:0];

    state_t      state, state_d;
    logic [15:0] lfsr;
    logic [5:0]  cnt, cnt_d;
    logic [63:0] bitmap, bitmap_d;
    logic [3:0]  placed_d;
    logic [3:0]  n, n_d;
    logic [2:0]  sx, sx_d, sy, sy_d;
    logic        busy_d, done_d, wr_en_d;
    logic [2:0]  wr_x_d, wr_y_d;
    logic [3:0]  wr_code_d;
    logic [5:0]  cand;

    // Popcount of the in-board 8-neighbours of (x,y); no wrap-around.
    function automatic logic [3:0] nbr_count(
        input logic [63:0] bm,
        input logic [2:0]  x,
        input logic [2:0]  y
    );
        logic [3:0] s;
        int nx, ny;
        s = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = int'(x) + dx;
                ny = int'(y) + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < 8 &&
                    ny >= 0 && ny < 8)
                    s = s + {3'b000, bm[6'(ny * 8 + nx)]};
            end
        end
        return s;
    endfunction

    function automatic logic excluded(
        input logic [5:0] c,
        input logic [2:0] px,
        input logic [2:0] py
    );
`ifdef SAFE_ZONE_EN
        logic [3:0] cx, cy, ax, ay;
        cx = {1'b0, c[2:0]};
        cy = {1'b0, c[5:3]};
        ax = {1'b0, px};
        ay = {1'b0, py};
        // 4-bit compare so the +1 never overflows at the board edge.
        return (cx + 4'd1 >= ax) && (ax + 4'd1 >= cx) &&
               (cy + 4'd1 >= ay) && (ay + 4'd1 >= cy);
`else
        return c == {py, px};
`endif
    endfunction

    assign cand = lfsr[5:0];

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bitmap_d  = bitmap;
        placed_d  = bus.placed;
        n_d       = n;
        sx_d      = sx;
        sy_d      = sy;
        busy_d    = bus.busy;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_x_d    = '0;
        wr_y_d    = '0;
        wr_code_d = '0;
        unique case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    n_d      = (32'(bus.bombas) > MAX_BOMBS) ? MAX_N
                                                             : bus.bombas;
                    sx_d     = bus.safe_x;
                    sy_d     = bus.safe_y;
                    bitmap_d = '0;
                    placed_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                wr_en_d = 1'b1;
                wr_x_d  = cnt[2:0];
                wr_y_d  = cnt[5:3];
                cnt_d   = cnt + 6'd1;
                if (cnt == 6'd63)
                    state_d = PLACE;
            end
            PLACE: begin
                // Quota test comes first, so n=0 still spends one cycle here.
                if (bus.placed == n) begin
                    cnt_d   = '0;
                    state_d = COUNT;
                end else if (!bitmap[cand] && !excluded(cand, sx, sy)) begin
                    bitmap_d[cand] = 1'b1;
                    placed_d       = bus.placed + 4'd1;
                end
            end
            COUNT: begin
                wr_en_d   = 1'b1;
                wr_x_d    = cnt[2:0];
                wr_y_d    = cnt[5:3];
                wr_code_d = bitmap[cnt] ? CODE_BOMB
                                        : nbr_count(bitmap, cnt[2:0], cnt[5:3]);
                cnt_d     = cnt + 6'd1;
                if (cnt == 6'd63)
                    state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            cnt         <= '0;
            bitmap      <= '0;
            n           <= '0;
            sx          <= '0;
            sy          <= '0;
            bus.placed  <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_x    <= '0;
            bus.wr_y    <= '0;
            bus.wr_code <= '0;
        end else begin
            state       <= state_d;
            // Fibonacci, taps 16,14,13,11; free-running in every state.
            lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            cnt         <= cnt_d;
            bitmap      <= bitmap_d;
            n           <= n_d;
            sx          <= sx_d;
            sy          <= sy_d;
            bus.placed  <= placed_d;
            bus.busy    <= busy_d;
            bus.done    <= done_d;
            bus.wr_en   <= wr_en_d;
            bus.wr_x    <= wr_x_d;
            bus.wr_y    <= wr_y_d;
            bus.wr_code <= wr_code_d;
        end
    end

endmodule

// File: tb/tb_mine_board_builder.sv
// Self-checking bench for mine_board_builder: a reference model predicts every
// write, the done cycle and bomb count; a negedge monitor pops and compares.
module tb_mine_board_builder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mine_board_builder_if bus ();

    mine_board_builder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int c; logic [9:0] w; } wr_t;
    typedef struct { int c; logic [3:0] placed; } dn_t;

    wr_t exp_q[$];
    dn_t done_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int b_t0 = -1;
    int b_td = -1;
    logic [15:0] m_lfsr;
    logic [63:0] obs_bm = '0;
    logic [63:0] cur_excl = '0;
    logic [63:0] last_mdl = '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic excl(input int cx, input int cy,
                                  input int px, input int py);
`ifdef SAFE_ZONE_EN
        return (cx - px <= 1) && (px - cx <= 1) &&
               (cy - py <= 1) && (py - cy <= 1);
`else
        return (cx == px) && (cy == py);
`endif
    endfunction

    always @(posedge clk or negedge reset)
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= step(m_lfsr);

    always @(posedge clk) cyc <= cyc + 1;

    // Drive at a negedge; the following posedge samples start.
    task automatic start_build(input int nb, input int px, input int py);
        int t0, n, p, placed, td;
        int cnt[64];
        logic [15:0] v;
        logic [63:0] bm;
        logic [5:0] c;
        logic [3:0] code;
        t0 = cyc + 1;
        bus.start  = 1'b1;
        bus.bombas = 4'(nb);
        bus.safe_x = 3'(px);
        bus.safe_y = 3'(py);
        if (t0 > b_td) begin
            n = (nb > 15) ? 15 : nb;
            v = m_lfsr;
            repeat (65) v = step(v);
            bm = '0;
            placed = 0;
            p = 0;
            forever begin
                p++;
                if (placed == n) break;
                c = v[5:0];
                if (!bm[c] && !excl(int'(c[2:0]), int'(c[5:3]), px, py)) begin
                    bm[c] = 1'b1;
                    placed++;
                end
                v = step(v);
            end
            for (int k = 0; k < 64; k++) cnt[k] = 0;
            for (int k = 0; k < 64; k++) begin
                if (bm[k]) begin
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++)
                            if (!(dx == 0 && dy == 0) && k % 8 + dx >= 0 &&
                                k % 8 + dx < 8 && k / 8 + dy >= 0 &&
                                k / 8 + dy < 8)
                                cnt[(k / 8 + dy) * 8 + k % 8 + dx]++;
                end
            end
            for (int k = 0; k < 64; k++)
                exp_q.push_back('{t0 + 1 + k, {3'(k % 8), 3'(k / 8), 4'd0}});
            for (int k = 0; k < 64; k++) begin
                code = bm[k] ? 4'd9 : 4'(cnt[k]);
                exp_q.push_back('{t0 + 65 + p + k,
                                  {3'(k % 8), 3'(k / 8), code}});
            end
            td = t0 + 129 + p;
            done_q.push_back('{td, 4'(n)});
            cur_excl = '0;
            for (int k = 0; k < 64; k++)
                cur_excl[k] = excl(k % 8, k / 8, px, py);
            last_mdl = bm;
            obs_bm = '0;
            b_t0 = t0;
            b_td = td;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("build_timeout", 64'(done_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        exp_q.delete();
        done_q.delete();
        b_t0 = -1;
        b_td = -1;
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_placed", 64'(bus.placed), 64'd0);
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("busy", 64'(bus.busy), 64'(cyc >= b_t0 && cyc < b_td));
            if (bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    check("wr_extra", 64'd1, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_cycle", 64'(cyc), 64'(e.c));
                    check("wr_data", 64'({bus.wr_x, bus.wr_y, bus.wr_code}),
                          64'(e.w));
                end
                if (bus.wr_code == 4'd9)
                    obs_bm[{bus.wr_y, bus.wr_x}] = 1'b1;
            end else begin
                check("wr_idle", 64'({bus.wr_x, bus.wr_y, bus.wr_code}), 64'd0);
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    check("done_extra", 64'd1, 64'd0);
                end else begin
                    dn_t d;
                    d = done_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d.c));
                    check("placed", 64'(bus.placed), 64'(d.placed));
                    check("bomb_count", 64'($countones(obs_bm)), 64'(d.placed));
                    check("safe_zone", obs_bm & cur_excl, 64'd0);
                end
            end
        end
    end

    logic [63:0] bm_a, bm_c, mdl_a, mdl_c;

    initial begin
        bus.start  = 1'b0;
        bus.bombas = '0;
        bus.safe_x = '0;
        bus.safe_y = '0;
        repeat (3) @(negedge clk);
        check("init_busy", 64'(bus.busy), 64'd0);
        check("init_wr_en", 64'(bus.wr_en), 64'd0);
        check("init_placed", 64'(bus.placed), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        start_build(0, 0, 0);
        wait_idle(400);

        start_build(10, 3, 4);
        wait_idle(400);
        check("placed_hold", 64'(bus.placed), 64'd10);

        start_build(15, 0, 0);
        wait_idle(600);

        start_build(12, 7, 7);
        repeat (67) @(negedge clk);
        start_build(3, 1, 1);
        wait_idle(600);

        start_build(15, 7, 0);
        wait_idle(600);

        start_build(5, 2, 2);
        begin
            int i;
            i = 0;
            while (exp_q.size() > 40 && i < 400) begin
                @(negedge clk);
                i++;
            end
        end
        pulse_reset();
        start_build(4, 1, 1);
        wait_idle(600);

        pulse_reset();
        repeat (5) @(negedge clk);
        start_build(10, 5, 5);
        mdl_a = last_mdl;
        wait_idle(600);
        bm_a = obs_bm;
        check("repeat_model", bm_a, mdl_a);

        pulse_reset();
        repeat (5) @(negedge clk);
        start_build(10, 5, 5);
        wait_idle(600);
        check("repeat_same", obs_bm, mdl_a);

        pulse_reset();
        repeat (6) @(negedge clk);
        start_build(10, 5, 5);
        mdl_c = last_mdl;
        wait_idle(600);
        bm_c = obs_bm;
        check("offset_differs", 64'(bm_a != bm_c), 64'(mdl_a != mdl_c));

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
